// File: rtl/mips_instr_encoder.sv
// Streaming MIPS32 instruction encoder: packs field-level requests into 32-bit words,
// expanding the LI pseudo-instruction into LUI/ORI, with a running byte address.
module mips_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [5:0]  req_op,
   input  logic [5:0]  req_func,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_shamt,
   input  logic [31:0] req_imm,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_word,
   output logic [31:0] instr_addr,
   output logic [15:0] instr_count
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_HOLD2 = 2'd2;

   localparam logic [1:0] KIND_R  = 2'd0;
   localparam logic [1:0] KIND_I  = 2'd1;
   localparam logic [1:0] KIND_J  = 2'd2;
   localparam logic [1:0] KIND_LI = 2'd3;

   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F;

   logic [1:0]  state_q, state_d;
   logic        valid_q, valid_d;
   logic [31:0] word_q, word_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;

   logic [31:0] first_word_s;
   logic [31:0] second_word_s;
   logic        two_word_s;
   logic        accept_s;
   logic        drain_s;
   logic [15:0] imm_hi_s;
   logic [15:0] imm_lo_s;

   assign imm_hi_s = req_imm[31:16];
   assign imm_lo_s = req_imm[15:0];

   // Encode the request into its first word and, for a split LI, the ORI that follows.
   always_comb begin
      first_word_s  = 32'h0000_0000;
      second_word_s = {OP_ORI, req_rt, req_rt, imm_lo_s};
      two_word_s    = 1'b0;
      case (req_kind)
         KIND_R:  first_word_s = {req_op, req_rs, req_rt, req_rd, req_shamt, req_func};
         KIND_I:  first_word_s = {req_op, req_rs, req_rt, req_imm[15:0]};
         KIND_J:  first_word_s = {req_op, req_imm[25:0]};
         KIND_LI: begin
            // A zero upper half needs only an ORI from $zero; otherwise LUI leads.
            if (imm_hi_s == 16'h0000) begin
               first_word_s = {OP_ORI, 5'd0, req_rt, imm_lo_s};
               two_word_s   = 1'b0;
            end else begin
               first_word_s = {OP_LUI, 5'd0, req_rt, imm_hi_s};
               two_word_s   = (imm_lo_s != 16'h0000);
            end
         end
         default: begin
            first_word_s = 32'h0000_0000;
            two_word_s   = 1'b0;
         end
      endcase
   end

   // Request-side readiness: only a single held word may be replaced in the same cycle it drains.
   always_comb begin
      case (state_q)
         ST_EMPTY: req_ready = 1'b1;
         ST_HOLD:  req_ready = instr_ready;
         ST_HOLD2: req_ready = 1'b0;
         default:  req_ready = 1'b0;
      endcase
   end

   assign accept_s = req_valid & req_ready;
   assign drain_s  = valid_q & instr_ready;

   // Next-state, held word and address/count bookkeeping.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      count_d = count_q;

      if (drain_s) begin
         addr_d = addr_q + 32'd4;
         if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
         end else begin
            count_d = count_q;
         end
      end else begin
         addr_d  = addr_q;
         count_d = count_q;
      end

      case (state_q)
         ST_EMPTY, ST_HOLD: begin
            if (accept_s) begin
               word_d  = first_word_s;
               pend_d  = second_word_s;
               state_d = two_word_s ? ST_HOLD2 : ST_HOLD;
            end else if (state_q == ST_HOLD && instr_ready) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = state_q;
            end
         end
         ST_HOLD2: begin
            if (instr_ready) begin
               word_d  = pend_q;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_HOLD2;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      valid_d = (state_d != ST_EMPTY);
   end

   // State and output registers; reset also discards any pending ORI.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         word_q  <= 32'h0000_0000;
         pend_q  <= 32'h0000_0000;
         addr_q  <= BASE_ADDR;
         count_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         word_q  <= word_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

   assign instr_valid = valid_q;
   assign instr_word  = word_q;
   assign instr_addr  = addr_q;
   assign instr_count = count_q;

endmodule
